spi_slave: RTL and testbench
============================

# spi_slave

SPI slave front end that pairs with the single-port RAM on the RAM's command/data interface. It deserializes 10-bit command frames from MOSI into `rx_data` with a one-cycle `rx_valid` strobe. For read-data frames it waits for the RAM's `tx_valid`, then serializes the returned byte MSB-first on MISO. It sits between the SPI pins and the RAM, and the pair together forms the SPI-to-memory path.

## Interface
- `FRAME_W`, 10: command frame width, `{cmd[1:0], payload[7:0]}`.
- `DATA_W`, 8: read-data width shifted out on MISO.
- `clk`  in  1  the single clock (SPI clock domain); all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `SS_n`  in  1  active-low slave select, sampled on `clk`.
- `MOSI`  in  1  serial data in, MSB first.
- `MISO`  out  1  serial data out, MSB first.
- `rx_data`  out  FRAME_W  assembled frame to the RAM.
- `rx_valid`  out  1  one-cycle strobe; `rx_data` is valid while it is high.
- `tx_data`  in  DATA_W  read byte from the RAM.
- `tx_valid`  in  1  one-cycle strobe from the RAM qualifying `tx_data`.

## Operation
- Command codes, `rx_data[9:8]`:
  - 00: write address.
  - 01: write data.
  - 10: read address.
  - 11: read data.
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- Internal flag `rd_addr_ok` is set when a READ_ADD frame completes and cleared when a READ_DATA frame completes.
- IDLE: when `SS_n`=0, go to CHK_CMD; otherwise stay.
- CHK_CMD:
  - Samples MOSI as frame bit 9 into the shift register.
  - `SS_n`=1 takes priority and goes to IDLE.
  - MOSI=0 goes to WRITE.
  - MOSI=1 with `rd_addr_ok`=0 goes to READ_ADD.
  - MOSI=1 with `rd_addr_ok`=1 goes to READ_DATA.
- WRITE, READ_ADD and READ_DATA:
  - Sample bits 8..0 on 9 consecutive cycles using a 4-bit counter.
  - After bit 0, register `rx_data` and pulse `rx_valid`.
  - Any further MOSI bits in the same frame are ignored until `SS_n`=1.
- READ_ADD completion sets `rd_addr_ok`.
- READ_DATA after `rx_valid`:
  - Clear `rd_addr_ok` and wait for `tx_valid`.
  - On `tx_valid`, capture `tx_data` into the output shifter.
  - Drive MISO with `tx_data[7]` down to `tx_data[0]` on the 8 following cycles, then drive MISO to 0.
  - `tx_valid` that arrives while a byte is shifting is ignored.
- `tx_valid` in any other state or phase is ignored.
- `SS_n`=1 in any non-IDLE state:
  - Next state is IDLE; that cycle's MOSI is not sampled.
  - A partial frame is discarded with no `rx_valid`.
  - Any MISO shift is aborted and MISO is 0 next cycle.
  - `rd_addr_ok` keeps its value.
- The FSM routes only on bit 9 and `rd_addr_ok`. `rx_data[8]` is forwarded unchanged, and the host is responsible for keeping it consistent with the route.

## Timing
- Reset values: state IDLE, `rx_data`=0, `rx_valid`=0, MISO=0, `rd_addr_ok`=0, counters 0.
- Cycle numbering (C0 is the first cycle with `SS_n` sampled low, in IDLE):
  - C1 (CHK_CMD) samples bit 9.
  - C2..C10 sample bits 8..0.
  - `rx_valid` is high in C11 only.
- Latency: 11 cycles from `SS_n` low to `rx_valid`.
- Read data with the RAM's registered response (`tx_valid` in C12):
  - MISO carries bit 7 in C13 through bit 0 in C20.
  - MISO is 0 again from C21.
- `rx_data` holds its value after `rx_valid` until the next completed frame.
- `SS_n` going high in the same cycle as bit 0 (C10): the frame is incomplete and no `rx_valid` is produced.
- `tx_valid` in the same cycle that `SS_n` is high: discarded.
- `rst` has priority over all events, including mid-frame and mid-shift.

## Structure
- Package `spi_pkg` holds:
  - The state enum typedef.
  - Command code constants: CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - `FRAME_W` and `DATA_W` defaults.
- Sub-module `spi_tx_shifter` contains:
  - The 8-bit load/shift register with a 3-bit count and busy flag.
  - An abort input driven by `SS_n`.
- The FSM and RX shift register live in the top module.

## Test plan
- Reset: assert `rst` for 2 cycles mid-frame. Required: all outputs are 0, state is IDLE, and no `rx_valid` follows.
- Write address: frame 0x0A5 (00_1010_0101). Required: `rx_data`=0x0A5 and `rx_valid` in C11 only.
- Write data: frame 0x13C. Required: `rx_data`=0x13C and a single-cycle `rx_valid`.
- Read sequence:
  - Stimulus: frame 0x2A5, then frame 0x300, with the RAM model returning `tx_data`=0xC3 one cycle after `rx_valid`.
  - Required: second frame routes to READ_DATA; MISO bits 1,1,0,0,0,0,1,1 in C13..C20; MISO is 0 from C21; `rd_addr_ok` is cleared.
- Abort: raise `SS_n` after bit 4 of a write frame. Required: no `rx_valid`; the next complete frame decodes correctly.
- Read data without a prior address: frame 0x300 issued with `rd_addr_ok`=0. Required: routes to READ_ADD and sets `rd_addr_ok`; MISO stays 0.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared widths, command codes and FSM state type for the SPI slave
package spi_pkg;
    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;
    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
endpackage

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus the RAM command/data handshake
interface spi_slave_if;
    import spi_pkg::*;
    logic               SS_n;
    logic               MOSI;
    logic               MISO;
    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_valid;
    modport slave  (input SS_n, MOSI, tx_data, tx_valid, output MISO, rx_data, rx_valid);
    modport master (output SS_n, MOSI, tx_data, tx_valid, input MISO, rx_data, rx_valid);
endinterface

// File: rtl/spi_tx_shifter.sv
// spi_tx_shifter: loads a read byte and shifts it out MSB-first, then idles MISO low
module spi_tx_shifter
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              abort,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    output logic              miso,
    output logic              busy
);
    logic [DATA_W-1:0] sh;
    logic [2:0]        cnt;
    // MISO is registered: the MSB appears the cycle after load, cnt counts remaining bits
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            sh   <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            miso <= 1'b0;
        end else if (load && !busy) begin
            sh   <= {din[DATA_W-2:0], 1'b0};
            cnt  <= 3'(DATA_W - 1);
            busy <= 1'b1;
            miso <= din[DATA_W-1];
        end else if (busy) begin
            sh   <= {sh[DATA_W-2:0], 1'b0};
            cnt  <= (cnt == 3'd0) ? cnt : cnt - 3'd1;
            busy <= cnt != 3'd0;
            miso <= (cnt == 3'd0) ? 1'b0 : sh[DATA_W-1];
        end
    end
endmodule

// File: rtl/spi_slave.sv
// spi_slave: deserializes 10-bit command frames and serializes RAM read bytes on MISO
module spi_slave
    import spi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    spi_slave_if.slave bus
);
    state_t             state, nxt;
    logic [3:0]         cnt;
    logic [FRAME_W-2:0] rx_shift;
    logic               rd_addr_ok, tx_wait, in_frame, sample, fin, load, busy;
    // state register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : nxt;
    end
    // routing uses only bit 9 and rd_addr_ok; SS_n high always returns to IDLE
    always_comb begin
        nxt = bus.SS_n ? IDLE :
              state == IDLE ? CHK_CMD :
              state == CHK_CMD ? (bus.MOSI ? (rd_addr_ok ? READ_DATA : READ_ADD) : WRITE) :
              state;
    end
    // sampling strobes: cnt reaching 9 marks a completed frame whose extra bits are ignored
    always_comb begin
        in_frame = state inside {WRITE, READ_ADD, READ_DATA};
        sample   = !bus.SS_n && (state == CHK_CMD || (in_frame && cnt != 4'd9));
        fin      = !bus.SS_n && in_frame && cnt == 4'd8;
        load     = tx_wait && bus.tx_valid && !bus.SS_n && !busy;
    end
    // receive shifter, frame output, read-address flag and wait-for-RAM flag
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            rx_shift     <= '0;
            bus.rx_data  <= '0;
            bus.rx_valid <= 1'b0;
            rd_addr_ok   <= 1'b0;
            tx_wait      <= 1'b0;
        end else begin
            bus.rx_valid <= fin;
            cnt          <= (state == IDLE) ? 4'd0 : (sample && in_frame) ? cnt + 4'd1 : cnt;
            rx_shift     <= sample ? {rx_shift[FRAME_W-3:0], bus.MOSI} : rx_shift;
            bus.rx_data  <= fin ? {rx_shift, bus.MOSI} : bus.rx_data;
            rd_addr_ok   <= (fin && state == READ_ADD) ? 1'b1 : (fin && state == READ_DATA) ? 1'b0 : rd_addr_ok;
            tx_wait      <= (fin && state == READ_DATA) ? 1'b1 : (load || bus.SS_n) ? 1'b0 : tx_wait;
        end
    end
    spi_tx_shifter u_tx (
        .clk   (clk),
        .rst   (rst),
        .abort (bus.SS_n),
        .load  (load),
        .din   (bus.tx_data),
        .miso  (bus.MISO),
        .busy  (busy)
    );
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: randomized frame stimulus checked against a frame-level reference model
module tb_spi_slave;
    import spi_pkg::*;
    localparam int LEN  = 28;
    localparam int NOAB = 26;
    logic clk = 1'b0;
    logic rst = 1'b1;
    spi_slave_if bus();
    spi_slave dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    int vectors = 0;
    int miscompares = 0;
    logic       m_rd_ok;
    logic [9:0] m_rx;
    logic       o_rv [LEN];
    logic       o_mi [LEN];
    logic [9:0] o_rd [LEN];
    logic       e_rv [LEN];
    logic       e_mi [LEN];
    logic [9:0] e_rd [LEN];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // drives one frame window: SS_n low from cycle 0 until cycle ab, frame bits in cycles 1..10
    task automatic drive_frame(input logic [9:0] f, input int ab, input int tx_at, input logic [7:0] txd);
        for (int k = 0; k < LEN; k++) begin
            o_rv[k] = bus.rx_valid;
            o_mi[k] = bus.MISO;
            o_rd[k] = bus.rx_data;
            bus.SS_n     = k >= ab;
            bus.MOSI     = (k >= 1 && k <= 10) ? f[10-k] : 1'($urandom);
            bus.tx_valid = (k == tx_at) ? 1'b1 : ((k <= 10 || (tx_at >= 0 && k > tx_at)) && $urandom_range(0, 3) == 0);
            bus.tx_data  = (k == tx_at) ? txd : 8'($urandom);
            tick();
        end
        bus.tx_valid = 1'b0;
    endtask

    // reference: a frame counts only if SS_n stays low through cycle 10; reads return bytes MSB-first
    task automatic model_frame(input logic [9:0] f, input int ab, input int tx_at, input logic [7:0] txd);
        bit done, rd_data, shifts;
        done    = ab > 10;
        rd_data = f[9] && m_rd_ok;
        shifts  = done && rd_data && tx_at >= 11 && tx_at < ab;
        for (int k = 0; k < LEN; k++) begin
            e_rv[k] = done && k == 11;
            e_rd[k] = (done && k >= 11) ? f : m_rx;
            e_mi[k] = (shifts && k > tx_at && k <= tx_at + 8 && k <= ab) ? txd[7-(k-tx_at-1)] : 1'b0;
        end
        if (done) begin
            m_rx = f;
            if (f[9]) m_rd_ok = !rd_data;
        end
    endtask

    task automatic test_reset;
        logic [9:0] fr [3];
        int         tx [3];
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        vectors++;
        if ({bus.rx_valid, bus.MISO, bus.rx_data} !== 12'h0) begin
            miscompares++;
            $display("FAIL reset_init: got rv=%b miso=%b rx=%03h, need all 0", bus.rx_valid, bus.MISO, bus.rx_data);
        end
        model_frame({CMD_RD_ADDR, 8'hA5}, NOAB, -1, 8'h00);
        drive_frame({CMD_RD_ADDR, 8'hA5}, NOAB, -1, 8'h00);
        for (int k = 0; k < LEN; k++) begin
            vectors++;
            if (o_rv[k] !== e_rv[k] || o_mi[k] !== e_mi[k] || o_rd[k] !== e_rd[k]) begin
                miscompares++;
                $display("FAIL reset_pre cyc %0d: got rv=%b miso=%b rx=%03h, need rv=%b miso=%b rx=%03h", k, o_rv[k], o_mi[k], o_rd[k], e_rv[k], e_mi[k], e_rd[k]);
            end
        end
        for (int k = 0; k < 6; k++) begin
            bus.SS_n = 1'b0;
            bus.MOSI = 1'($urandom);
            tick();
        end
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bus.SS_n = 1'b1;
        m_rx = '0;
        m_rd_ok = 1'b0;
        for (int k = 0; k < 14; k++) begin
            vectors++;
            if ({bus.rx_valid, bus.MISO, bus.rx_data} !== 12'h0) begin
                miscompares++;
                $display("FAIL reset_mid cyc %0d: got rv=%b miso=%b rx=%03h, need all 0", k, bus.rx_valid, bus.MISO, bus.rx_data);
            end
            tick();
        end
        fr = '{10'h3C3, 10'h35A, 10'h0F0};
        tx = '{12, 13, -1};
        for (int i = 0; i < 3; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            model_frame(fr[i], NOAB, tx[i], d);
            drive_frame(fr[i], NOAB, tx[i], d);
            for (int k = 0; k < LEN; k++) begin
                vectors++;
                if (o_rv[k] !== e_rv[k] || o_mi[k] !== e_mi[k] || o_rd[k] !== e_rd[k]) begin
                    miscompares++;
                    $display("FAIL reset_post frame %03h cyc %0d: got rv=%b miso=%b rx=%03h, need rv=%b miso=%b rx=%03h", fr[i], k, o_rv[k], o_mi[k], o_rd[k], e_rv[k], e_mi[k], e_rd[k]);
                end
            end
        end
    endtask

    task automatic test_write;
        logic [9:0] fr [2];
        fr = '{{CMD_WR_ADDR, 8'hA5}, {CMD_WR_DATA, 8'h3C}};
        for (int i = 0; i < 2; i++) begin
            model_frame(fr[i], NOAB, -1, 8'h00);
            drive_frame(fr[i], NOAB, -1, 8'h00);
            for (int k = 0; k < LEN; k++) begin
                vectors++;
                if (o_rv[k] !== e_rv[k] || o_mi[k] !== e_mi[k] || o_rd[k] !== e_rd[k]) begin
                    miscompares++;
                    $display("FAIL write frame %03h cyc %0d: got rv=%b miso=%b rx=%03h, need rv=%b miso=%b rx=%03h", fr[i], k, o_rv[k], o_mi[k], o_rd[k], e_rv[k], e_mi[k], e_rd[k]);
                end
            end
        end
    endtask

    task automatic test_read_seq;
        logic [9:0] fr [2];
        fr = '{{CMD_RD_ADDR, 8'hA5}, {CMD_RD_DATA, 8'h00}};
        for (int i = 0; i < 2; i++) begin
            model_frame(fr[i], NOAB, 12, 8'hC3);
            drive_frame(fr[i], NOAB, 12, 8'hC3);
            for (int k = 0; k < LEN; k++) begin
                vectors++;
                if (o_rv[k] !== e_rv[k] || o_mi[k] !== e_mi[k] || o_rd[k] !== e_rd[k]) begin
                    miscompares++;
                    $display("FAIL read_seq frame %03h cyc %0d: got rv=%b miso=%b rx=%03h, need rv=%b miso=%b rx=%03h", fr[i], k, o_rv[k], o_mi[k], o_rd[k], e_rv[k], e_mi[k], e_rd[k]);
                end
            end
        end
    endtask

    task automatic test_abort;
        logic [9:0] fr [2];
        int         ab [2];
        fr = '{{CMD_WR_DATA, 8'($urandom)}, {1'b0, 9'($urandom)}};
        ab = '{7, NOAB};
        for (int i = 0; i < 2; i++) begin
            model_frame(fr[i], ab[i], -1, 8'h00);
            drive_frame(fr[i], ab[i], -1, 8'h00);
            for (int k = 0; k < LEN; k++) begin
                vectors++;
                if (o_rv[k] !== e_rv[k] || o_mi[k] !== e_mi[k] || o_rd[k] !== e_rd[k]) begin
                    miscompares++;
                    $display("FAIL abort frame %03h cyc %0d: got rv=%b miso=%b rx=%03h, need rv=%b miso=%b rx=%03h", fr[i], k, o_rv[k], o_mi[k], o_rd[k], e_rv[k], e_mi[k], e_rd[k]);
                end
            end
        end
    endtask

    task automatic test_rd_no_addr;
        logic [9:0] fr [2];
        fr = '{{CMD_RD_DATA, 8'h00}, {CMD_RD_DATA, 8'($urandom)}};
        for (int i = 0; i < 2; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            model_frame(fr[i], NOAB, 12, d);
            drive_frame(fr[i], NOAB, 12, d);
            for (int k = 0; k < LEN; k++) begin
                vectors++;
                if (o_rv[k] !== e_rv[k] || o_mi[k] !== e_mi[k] || o_rd[k] !== e_rd[k]) begin
                    miscompares++;
                    $display("FAIL rd_no_addr frame %03h cyc %0d: got rv=%b miso=%b rx=%03h, need rv=%b miso=%b rx=%03h", fr[i], k, o_rv[k], o_mi[k], o_rd[k], e_rv[k], e_mi[k], e_rd[k]);
                end
            end
        end
    endtask

    task automatic test_boundary;
        logic [9:0] fr [5];
        int         ab [5];
        int         tx [5];
        fr = '{{CMD_WR_ADDR, 8'h5A}, {CMD_RD_ADDR, 8'h11}, {CMD_RD_DATA, 8'h22}, {CMD_RD_ADDR, 8'h33}, {CMD_RD_DATA, 8'h44}};
        ab = '{10, NOAB, 13, NOAB, 16};
        tx = '{-1, -1, 13, -1, 12};
        for (int i = 0; i < 5; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            model_frame(fr[i], ab[i], tx[i], d);
            drive_frame(fr[i], ab[i], tx[i], d);
            for (int k = 0; k < LEN; k++) begin
                vectors++;
                if (o_rv[k] !== e_rv[k] || o_mi[k] !== e_mi[k] || o_rd[k] !== e_rd[k]) begin
                    miscompares++;
                    $display("FAIL boundary frame %03h ab %0d cyc %0d: got rv=%b miso=%b rx=%03h, need rv=%b miso=%b rx=%03h", fr[i], ab[i], k, o_rv[k], o_mi[k], o_rd[k], e_rv[k], e_mi[k], e_rd[k]);
                end
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            logic [9:0] f;
            logic [7:0] d;
            int         ab, tx;
            f  = 10'($urandom);
            d  = 8'($urandom);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 24)) : NOAB;
            tx = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(12, 15));
            model_frame(f, ab, tx, d);
            drive_frame(f, ab, tx, d);
            for (int k = 0; k < LEN; k++) begin
                vectors++;
                if (o_rv[k] !== e_rv[k] || o_mi[k] !== e_mi[k] || o_rd[k] !== e_rd[k]) begin
                    miscompares++;
                    $display("FAIL random frame %03h ab %0d tx %0d cyc %0d: got rv=%b miso=%b rx=%03h, need rv=%b miso=%b rx=%03h", f, ab, tx, k, o_rv[k], o_mi[k], o_rd[k], e_rv[k], e_mi[k], e_rd[k]);
                end
            end
        end
    endtask

    initial begin
        bus.SS_n     = 1'b1;
        bus.MOSI     = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        m_rd_ok      = 1'b0;
        m_rx         = '0;
        test_reset();
        test_write();
        test_read_seq();
        test_abort();
        test_rd_no_addr();
        test_boundary();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
